// File: rtl/alu32_exec_unit.sv
// rtl/alu32_exec_unit.sv - registered execute stage: ALU control, 32-bit ALU, next-PC adders
// Optional ALU_NOR_EN adds funct 0111 -> NOR (gout 100).
module alu32_exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        aluop1,
  input  logic        aluop0,
  input  logic [3:0]  funct,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  input  logic [31:0] pc,
  input  logic [31:0] extad,
  output logic        out_valid,
  output logic [2:0]  gout,
  output logic [31:0] sum,
  output logic        zout,
  output logic [31:0] adder1out,
  output logic [31:0] adder2out
);

  logic [2:0]  gctl;
  logic [31:0] result;
  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;

  always_comb begin
    gctl = 3'b010;
    case ({aluop1, aluop0})
      2'b00: gctl = 3'b010;
      2'b01: gctl = 3'b110;
      2'b11: gctl = 3'b001;
      2'b10: begin
        case (funct)
          4'b0000: gctl = 3'b010;
          4'b0010: gctl = 3'b110;
          4'b0100: gctl = 3'b000;
          4'b0101: gctl = 3'b001;
          4'b1010: gctl = 3'b111;
`ifdef ALU_NOR_EN
          4'b0111: gctl = 3'b100;
`endif
          default: gctl = 3'b010;
        endcase
      end
      default: gctl = 3'b010;
    endcase
  end

  // slt uses a true signed compare so it stays correct when a-b overflows
  always_comb begin
    result = 32'h0;
    case (gctl)
      3'b000: result = dataa & datab;
      3'b001: result = dataa | datab;
      3'b010: result = dataa + datab;
      3'b110: result = dataa - datab;
      3'b111: result = {31'h0, ($signed(dataa) < $signed(datab))};
`ifdef ALU_NOR_EN
      3'b100: result = ~(dataa | datab);
`endif
      default: result = 32'h0;
    endcase
  end

  assign pc_plus4   = pc + 32'd4;
  assign branch_tgt = pc_plus4 + (extad << 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      gout      <= 3'b000;
      sum       <= 32'h0;
      zout      <= 1'b0;
      adder1out <= 32'h0;
      adder2out <= 32'h0;
    end else begin
      out_valid <= in_valid;
      gout      <= gctl;
      sum       <= result;
      zout      <= (result == 32'h0);
      adder1out <= pc_plus4;
      adder2out <= branch_tgt;
    end
  end

endmodule

// File: tb/tb_alu32_exec_unit.sv
// tb/tb_alu32_exec_unit.sv - directed self-checking bench for alu32_exec_unit
module tb_alu32_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        aluop1, aluop0;
  logic [3:0]  funct;
  logic [31:0] dataa, datab, pc, extad;
  logic        out_valid;
  logic [2:0]  gout;
  logic [31:0] sum;
  logic        zout;
  logic [31:0] adder1out, adder2out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu32_exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .aluop1(aluop1), .aluop0(aluop0), .funct(funct),
    .dataa(dataa), .datab(datab), .pc(pc), .extad(extad),
    .out_valid(out_valid), .gout(gout), .sum(sum), .zout(zout),
    .adder1out(adder1out), .adder2out(adder2out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] e);
    {aluop1, aluop0} = op;
    funct = f;
    dataa = a;
    datab = b;
    pc    = p;
    extad = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    drive(2'b00, 4'h0, 32'd5, 32'd5, 32'h100, 32'h1);
    drive(2'b00, 4'h0, 32'd5, 32'd5, 32'h100, 32'h1);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_gout", {29'h0, gout}, 32'h0);
    check("rst_sum", sum, 32'h0);
    check("rst_zout", {31'h0, zout}, 32'h0);
    check("rst_add1", adder1out, 32'h0);
    check("rst_add2", adder2out, 32'h0);

    rst = 1'b0;
    drive(2'b00, 4'h0, 32'd5, 32'd5, 32'h100, 32'h1);
    check("post_rst_sum", sum, 32'h0000000A);
    check("post_rst_valid", {31'h0, out_valid}, 32'h1);
    check("post_rst_add2", adder2out, 32'h108);

    drive(2'b10, 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0);
    check("radd_sum", sum, 32'h80000000);
    check("radd_zout", {31'h0, zout}, 32'h0);
    check("radd_gout", {29'h0, gout}, 32'h2);

    drive(2'b10, 4'b0010, 32'h1234, 32'h1234, 32'h0, 32'h0);
    check("rsub_sum", sum, 32'h0);
    check("rsub_zout", {31'h0, zout}, 32'h1);
    check("rsub_gout", {29'h0, gout}, 32'h6);

    drive(2'b10, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    check("and_sum", sum, 32'hF000F000);
    check("and_gout", {29'h0, gout}, 32'h0);
    drive(2'b10, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0);
    check("or_sum", sum, 32'hFFF0FFF0);
    drive(2'b10, 4'b1010, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0);
    check("slt_neg_sum", sum, 32'h1);
    check("slt_gout", {29'h0, gout}, 32'h7);
    drive(2'b10, 4'b1010, 32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h0);
    check("slt_pos_sum", sum, 32'h0);
    check("slt_pos_zout", {31'h0, zout}, 32'h1);
    drive(2'b10, 4'b1111, 32'd3, 32'd4, 32'h0, 32'h0);
    check("dflt_sum", sum, 32'h7);
    check("dflt_gout", {29'h0, gout}, 32'h2);

    drive(2'b01, 4'b1010, 32'd7, 32'd7, 32'h10, 32'hFFFFFFFE);
    check("beq_gout", {29'h0, gout}, 32'h6);
    check("beq_zout", {31'h0, zout}, 32'h1);
    check("beq_add1", adder1out, 32'h14);
    check("beq_add2", adder2out, 32'h0C);

    drive(2'b00, 4'b0010, 32'd8, 32'd4, 32'h0, 32'h0);
    check("lw_sum", sum, 32'h0C);
    drive(2'b11, 4'b0100, 32'h00F0, 32'h000F, 32'hFFFFFFFC, 32'h1);
    check("ori_sum", sum, 32'h00FF);
    check("ori_gout", {29'h0, gout}, 32'h1);
    check("wrap_add1", adder1out, 32'h0);
    check("wrap_add2", adder2out, 32'h4);

    in_valid = 1'b0;
    drive(2'b00, 4'h0, 32'd1, 32'd2, 32'h0, 32'h0);
    check("inval_valid", {31'h0, out_valid}, 32'h0);
    check("inval_sum", sum, 32'h3);
    in_valid = 1'b1;

    drive(2'b10, 4'b0111, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef ALU_NOR_EN
    check("nor_sum", sum, 32'hFFFFFFFF);
    check("nor_gout", {29'h0, gout}, 32'h4);
`else
    check("nor_off_sum", sum, 32'h0);
    check("nor_off_gout", {29'h0, gout}, 32'h2);
`endif

    rst = 1'b1;
    drive(2'b00, 4'h0, 32'd9, 32'd9, 32'h40, 32'h0);
    check("rst2_valid", {31'h0, out_valid}, 32'h0);
    check("rst2_sum", sum, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
